// File: rtl/mdu_seq_pkg.sv
// Shared opcode and state definitions for the sequential multiply/divide unit.
// Opcode values match the alucontrol encoding driven by the decode stage.
package mdu_seq_pkg;

    localparam int OP_WIDTH = 8;

    localparam logic [OP_WIDTH-1:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [OP_WIDTH-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [OP_WIDTH-1:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [OP_WIDTH-1:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [OP_WIDTH-1:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on unsigned magnitudes: a right-shifting shift-add
// multiply step or a left-shifting restoring divide step.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] mq_i,
    input  logic [WIDTH-1:0] mcand_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mq_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic           fits;

    always_comb begin
        acc_o  = acc_i;
        mq_o   = mq_i;
        sum    = '0;
        rem_sh = '0;
        fits   = 1'b0;
        if (is_div_i) begin
            // A successful subtract always leaves less than the divisor, so WIDTH bits suffice.
            rem_sh = {acc_i, mq_i[WIDTH-1]};
            fits   = (rem_sh >= {1'b0, mcand_i});
            if (fits) begin
                acc_o = rem_sh[WIDTH-1:0] - mcand_i;
            end else begin
                acc_o = rem_sh[WIDTH-1:0];
            end
            mq_o = {mq_i[WIDTH-2:0], fits};
        end else begin
            sum   = {1'b0, acc_i} + (mq_i[0] ? {1'b0, mcand_i} : '0);
            acc_o = sum[WIDTH:1];
            mq_o  = {sum[0], mq_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit: WIDTH radix-2 steps on magnitudes,
// followed by one sign-fix cycle and a one-cycle registered valid pulse.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e       state_q;
    logic [CW-1:0]    count_q;
    logic             is_div_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             bzero_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mq_q;
    logic [WIDTH-1:0] mcand_q;
    logic             busy_q;
    logic             valid_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dz_q;

    logic             op_mult, op_multu, op_div, op_divu;
    logic             op_known, op_signed, op_is_div;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] step_acc, step_mq;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign op_mult   = (op == OPW'(EXE_MULT_OP));
    assign op_multu  = (op == OPW'(EXE_MULTU_OP));
    assign op_div    = (op == OPW'(EXE_DIV_OP));
    assign op_divu   = (op == OPW'(EXE_DIVU_OP));
    assign op_known  = op_mult | op_multu | op_div | op_divu;
    assign op_signed = op_mult | op_div;
    assign op_is_div = op_div | op_divu;

    assign sign_a = op_signed & a[WIDTH-1];
    assign sign_b = op_signed & b[WIDTH-1];
    assign abs_a  = sign_a ? -a : a;
    assign abs_b  = sign_b ? -b : b;

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .mq_i     (mq_q),
        .mcand_i  (mcand_q),
        .acc_o    (step_acc),
        .mq_o     (step_mq)
    );

    // With a zero divisor the restoring loop leaves |a| as remainder, so the
    // usual remainder sign fix reproduces the original dividend in hi.
    assign prod_raw = {acc_q, mq_q};
    assign prod_fix = neg_res_q ? -prod_raw : prod_raw;
    assign quot_fix = bzero_q ? {WIDTH{1'b1}} : (neg_res_q ? -mq_q : mq_q);
    assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && op_known && !cancel) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        count_q   <= '0;
                        is_div_q  <= op_is_div;
                        neg_res_q <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        bzero_q   <= (b == '0);
                        acc_q     <= '0;
                        mq_q      <= op_is_div ? abs_a : abs_b;
                        mcand_q   <= op_is_div ? abs_b : abs_a;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q   <= step_acc;
                        mq_q    <= step_mq;
                        count_q <= count_q + CW'(1);
                        if (count_q == CW'(WIDTH - 1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    state_q <= cancel ? IDLE : DONE;
                    busy_q  <= 1'b0;
                    if (!cancel) begin
                        if (is_div_q) begin
                            lo_q <= quot_fix;
                            hi_q <= rem_fix;
                            dz_q <= bzero_q;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                    end
                end
                DONE: begin
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign dz    = dz_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: expected results come from plain integer
// arithmetic and are checked by an independent monitor on each valid pulse.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 2;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        valid;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   acceptCyc;
    exp_t sbq[$];
    exp_t monExp;

    logic [31:0] curHi = '0, curLo = '0;
    logic        curDz = 1'b0;
    logic [31:0] savHi, savLo;
    logic        savDz;

    logic [7:0] opTable[4] = '{EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP};

    mdu_seq #(
        .WIDTH (WIDTH),
        .OPW   (8)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .valid  (valid),
        .hi     (hi),
        .lo     (lo),
        .dz     (dz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic refModel(input logic [7:0] opc, input logic [31:0] x, input logic [31:0] y,
                            output logic [31:0] rHi, output logic [31:0] rLo, output logic rDz);
        longint      sx, sy;
        logic [63:0] t;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        rDz = curDz;
        rHi = '0;
        rLo = '0;
        case (opc)
            EXE_MULT_OP: begin
                t = sx * sy;
                {rHi, rLo} = t;
            end
            EXE_MULTU_OP: begin
                t = {32'b0, x} * {32'b0, y};
                {rHi, rLo} = t;
            end
            EXE_DIV_OP, EXE_DIVU_OP: begin
                if (y == 32'd0) begin
                    rLo = 32'hFFFF_FFFF;
                    rHi = x;
                    rDz = 1'b1;
                end else begin
                    rDz = 1'b0;
                    if (opc == EXE_DIV_OP) begin
                        t   = sx / sy;
                        rLo = t[31:0];
                        t   = sx % sy;
                        rHi = t[31:0];
                    end else begin
                        rLo = x / y;
                        rHi = x % y;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // Drive one request at a negedge; the following posedge is the accept edge.
    task automatic applyStimulus(input logic [7:0] opc, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] rHi, rLo;
        logic        rDz;
        @(negedge clk);
        start = 1'b1;
        op    = opc;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start     = 1'b0;
        acceptCyc = cyc;
        checkOutput("busy_after_accept", busy, 1);
        refModel(opc, x, y, rHi, rLo, rDz);
        savHi = curHi;
        savLo = curLo;
        savDz = curDz;
        curHi = rHi;
        curLo = rLo;
        curDz = rDz;
        sbq.push_back('{rHi, rLo, rDz, acceptCyc + LATENCY});
    endtask

    task automatic waitDrain(input int limit);
        for (int i = 0; i < limit && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            checkOutput("result_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic runOp(input logic [7:0] opc, input logic [31:0] x, input logic [31:0] y);
        applyStimulus(opc, x, y);
        waitDrain(LATENCY + 10);
    endtask

    // Raise cancel so that it is sampled on the (k+1)-th edge after accept.
    task automatic runCancel(input logic [7:0] opc, input logic [31:0] x, input logic [31:0] y,
                             input int k, input bit aborts);
        applyStimulus(opc, x, y);
        repeat (k + 1) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        if (aborts) begin
            void'(sbq.pop_back());
            curHi = savHi;
            curLo = savLo;
            curDz = savDz;
            checkOutput("cancel_busy", busy, 0);
            checkOutput("cancel_hi", hi, curHi);
            checkOutput("cancel_lo", lo, curLo);
            checkOutput("cancel_dz", dz, curDz);
            runOp(opTable[$urandom_range(0, 3)], $urandom, $urandom);
        end else begin
            waitDrain(LATENCY + 10);
        end
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] specials[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    always @(negedge clk) begin
        if (resetn && valid) begin
            if (sbq.size() == 0) begin
                checkOutput("spurious_valid", valid, 0);
            end else begin
                monExp = sbq.pop_front();
                checkOutput("latency", cyc, monExp.due);
                checkOutput("hi", hi, monExp.hi);
                checkOutput("lo", lo, monExp.lo);
                checkOutput("dz", dz, monExp.dz);
            end
        end
    end

    initial begin
        start  = 1'b0;
        cancel = 1'b0;
        op     = '0;
        a      = '0;
        b      = '0;
        resetn = 1'b1;
        #3 resetn = 1'b0;
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);
        checkOutput("reset_dz", dz, 0);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;

        runOp(EXE_MULT_OP,  32'hFFFF_FFFE, 32'd3);
        runOp(EXE_MULTU_OP, 32'hFFFF_FFFE, 32'd3);
        runOp(EXE_DIV_OP,   32'hFFFF_FFF9, 32'd2);
        runOp(EXE_DIV_OP,   32'h8000_0000, 32'hFFFF_FFFF);
        runOp(EXE_DIVU_OP,  32'd7,         32'd0);
        runOp(EXE_MULT_OP,  32'd5,         32'd6);
        runOp(EXE_DIV_OP,   32'hFFFF_FFF9, 32'd0);
        runOp(EXE_MULT_OP,  32'h8000_0000, 32'h8000_0000);
        runOp(EXE_DIV_OP,   32'd7,         32'hFFFF_FFFE);

        runCancel(EXE_DIV_OP,   32'd1000,  32'd7, 9,  1'b1);
        runCancel(EXE_MULT_OP,  $urandom,  $urandom, WIDTH - 1, 1'b1);
        runCancel(EXE_DIVU_OP,  $urandom,  32'd3, WIDTH, 1'b1);
        runCancel(EXE_MULTU_OP, $urandom,  $urandom, WIDTH + 1, 1'b0);

        // Start held high for the whole operation with operands churning.
        @(negedge clk);
        start = 1'b1;
        op    = EXE_MULTU_OP;
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        acceptCyc = cyc;
        checkOutput("held_busy", busy, 1);
        begin
            logic [31:0] rHi, rLo;
            logic        rDz;
            refModel(EXE_MULTU_OP, 32'h1234_5678, 32'h9ABC_DEF0, rHi, rLo, rDz);
            curHi = rHi;
            curLo = rLo;
            curDz = rDz;
            sbq.push_back('{rHi, rLo, rDz, acceptCyc + LATENCY});
        end
        for (int i = 0; i < LATENCY + 10 && busy; i++) begin
            @(negedge clk);
            op = opTable[$urandom_range(0, 3)];
            a  = $urandom;
            b  = $urandom;
        end
        start = 1'b0;
        waitDrain(LATENCY + 10);

        @(negedge clk);
        start = 1'b1;
        op    = EXE_ADD_OP;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("add_ignored", busy, 0);
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        op     = EXE_DIV_OP;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        checkOutput("start_cancel_ignored", busy, 0);
        repeat (LATENCY + 5) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            runOp(opTable[$urandom_range(0, 3)], pickOperand(), pickOperand());
        end

        // Reset in the middle of a run clears everything immediately.
        applyStimulus(EXE_MULT_OP, $urandom, $urandom);
        repeat (6) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        sbq.delete();
        curHi = '0;
        curLo = '0;
        curDz = 1'b0;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_valid", valid, 0);
        checkOutput("midreset_hi", hi, 0);
        checkOutput("midreset_lo", lo, 0);
        checkOutput("midreset_dz", dz, 0);
        @(posedge clk);
        #2 resetn = 1'b1;
        repeat (LATENCY + 5) @(negedge clk);
        runOp(EXE_DIVU_OP, 32'd100, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving operand and result width (even, >=8).
REQ-002 SHALL have parameter OPW, default 8, giving opcode width (matches alucontrol).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 resetn  input  1  reset; asynchronous assert, active-low.
REQ-005 start  input  1  request to begin an operation.
REQ-006 op  input  OPW  alucontrol code; only the MULT/MULTU/DIV/DIVU opcodes are recognised.
REQ-007 a, b  input  WIDTH each  first/second operand (multiplicand/dividend, multiplier/divisor).
REQ-008 cancel  input  1  pipeline flush; aborts any operation in flight.
REQ-009 busy  output  1  high from the accept edge until the result is delivered or cancelled.
REQ-010 valid  output  1  one-cycle pulse: hi/lo/dz hold a new result.
REQ-011 hi, lo  output  WIDTH each  result registers.
REQ-012 dz  output  1  the last divide had b==0.

Function
REQ-013 SHALL use FSM states IDLE, RUN, FIX, DONE.
REQ-014 IDLE: start=1, recognised op, cancel=0 -> accept. Latch op, sign flags, |a|, |b| (raw for unsigned ops), count=0 -> RUN.
REQ-015 IDLE: start with an unrecognised op SHALL be ignored: no busy, no state change.
REQ-016 RUN SHALL do one radix-2 step per cycle (shift-add multiply or restoring divide) for exactly WIDTH cycles, then go to FIX.
REQ-017 FIX SHALL apply signed correction (negate the 2*WIDTH product if signs differ; quotient negative if signs differ; remainder takes the dividend's sign), load hi/lo, then go to DONE.
REQ-018 DONE SHALL assert valid for exactly one cycle, then go to IDLE; busy SHALL be low in DONE.
REQ-019 valid SHALL be high in the cycle after the WIDTH+2-th rising edge following the accept edge (latency WIDTH+2; 34 at WIDTH=32).
REQ-020 Multiply SHALL give hi = upper WIDTH bits and lo = lower WIDTH bits of the full product.
REQ-021 Divide SHALL give lo = quotient and hi = remainder, truncating toward zero.
REQ-022 b==0 on DIV/DIVU SHALL give lo = all ones, hi = a and dz=1, with unchanged latency; otherwise dz=0 on divide results.
REQ-023 Signed most-negative / -1 SHALL give lo = most-negative and hi = 0, with no flag.
REQ-024 start while busy or in DONE SHALL be ignored.
REQ-025 cancel=1 in RUN or FIX SHALL return the FSM to IDLE at the next edge: no valid pulse, hi/lo/dz unchanged.
REQ-026 cancel=1 in DONE SHALL NOT suppress the valid pulse already in progress.
REQ-027 cancel and start in the same IDLE cycle: cancel wins, nothing is accepted.
REQ-028 hi, lo and dz SHALL hold their values between results.

Reset
REQ-029 resetn=0 SHALL immediately force state=IDLE, busy=0, valid=0, hi=0, lo=0, dz=0, count=0 and clear internal datapath registers.
REQ-030 Reset during an operation SHALL abort it; no valid after resetn rises.
REQ-031 The first start is accepted on the first rising edge with resetn=1.

Structure
REQ-032 The opcodes (EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP) and FSM state encodings SHALL come from the shared defines header, not local literals.
REQ-033 One combinational sub-module, mdu_step, SHALL implement a single shift-add/restoring step, parametrised by WIDTH; mdu_seq holds the FSM, counter and registers.

Verification
REQ-034 MULT a=0xFFFFFFFE, b=3 -> valid 34 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-035 DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, dz=0. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7, dz=1, latency 34.
REQ-037 Accept, cancel on cycle 10 -> busy low next cycle, no valid, hi/lo unchanged; a new start the following cycle is accepted and completes normally.
REQ-038 Back-to-back: a start pulse held through busy is ignored, and start with op=EXE_ADD_OP is ignored. Reset asserted mid-RUN -> all outputs 0 at once; no valid after release.
